// File: rtl/pipeline_ctrl_pkg.sv
// Shared defines for the pipeline controller: exception vector, stall-bus
//   patterns, FSM state encodings and the polarity constants.
// Latency: n/a (declarations only). Backpressure: n/a.
package pipeline_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;

  localparam int unsigned STALL_W = 6;

  // Stall patterns are contiguous from the PC upward: holding a stage
  // means every earlier stage has to hold too.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;  // PC, IF/ID, ID
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;  // PC .. EX

  localparam logic STOP         = 1'b1;  // stall bus value meaning "hold"
  localparam logic JUMP_ENABLE  = 1'b1;  // PC register jump enable level
  localparam logic RST_ENABLE   = 1'b0;  // reset asserted level

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // True when the PC-stage hold bit is set.
  function automatic logic pc_held(input logic [STALL_W-1:0] s);
    return s[0] == STOP;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Request/response bundle between the pipeline stages and the controller.
//   Ports: stall/exception requests and epc in; stall bus, flush, redirect,
//   new_pc and stall_cnt out. Latency/backpressure: defined by the controller.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic               stallreq_id;
  logic               stallreq_ex;
  logic               exc_req;
  logic               eret_req;
  logic [31:0]        epc_i;
  logic               cnt_clr;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               redirect;
  logic [31:0]        new_pc;
  logic [CNT_W-1:0]   stall_cnt;

  // Pipeline side: raises requests, consumes the control outputs.
  modport master (
    output stallreq_id, stallreq_ex, exc_req, eret_req, epc_i, cnt_clr,
    input  stall, flush, redirect, new_pc, stall_cnt
  );

  // Controller side.
  modport slave (
    input  stallreq_id, stallreq_ex, exc_req, eret_req, epc_i, cnt_clr,
    output stall, flush, redirect, new_pc, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   Latency: 1 cycle from inc/clr to cnt. Backpressure: none, sticks at max.
//   Ports: clk, rst (async active-low), inc, clr in; cnt out.
module pipeline_ctrl_sat_cnt
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: stall bus, flush and PC redirect.
//   Latency: 1 cycle, all outputs registered. Backpressure: none; requests
//   arriving during FLUSH/DRAIN are dropped (they belong to squashed slots).
//   Ports: clk, rst (async active-low), bus (pipeline_ctrl_if.slave).
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  state_t             state;
  logic [STALL_W-1:0] stall_q;
  logic               flush_q;
  logic               redirect_q;
  logic [31:0]        new_pc_q;
  logic [CNT_W-1:0]   cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state      <= S_RUN;
      stall_q    <= STALL_NONE;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      new_pc_q   <= 32'h0;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.exc_req) begin
            state      <= S_FLUSH;
            stall_q    <= STALL_NONE;
            flush_q    <= 1'b1;
            redirect_q <= JUMP_ENABLE;
            new_pc_q   <= EXC_VECTOR;
          end else if (bus.eret_req) begin
            state      <= S_FLUSH;
            stall_q    <= STALL_NONE;
            flush_q    <= 1'b1;
            redirect_q <= JUMP_ENABLE;
            new_pc_q   <= bus.epc_i;
          end else if (bus.stallreq_ex) begin
            stall_q    <= STALL_EX;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
          end else if (bus.stallreq_id) begin
            stall_q    <= STALL_ID;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
          end else begin
            stall_q    <= STALL_NONE;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
          end
        end
        // Second flush cycle clears whatever the redirected fetch
        // overlapped with; the jump itself has already been taken.
        S_FLUSH: begin
          state      <= S_DRAIN;
          stall_q    <= STALL_NONE;
          flush_q    <= 1'b1;
          redirect_q <= 1'b0;
        end
        S_DRAIN: begin
          state      <= S_RUN;
          stall_q    <= STALL_NONE;
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
        default: begin
          state      <= S_RUN;
          stall_q    <= STALL_NONE;
          flush_q    <= 1'b0;
          redirect_q <= 1'b0;
        end
      endcase
    end
  end

  // Counts edges at which the registered PC hold bit is set.
  pipeline_ctrl_sat_cnt sat_cnt16 (
    .clk (clk),
    .rst (rst),
    .inc (pc_held(stall_q)),
    .clr (bus.cnt_clr),
    .cnt (cnt)
  );

  assign bus.stall     = stall_q;
  assign bus.flush     = flush_q;
  assign bus.redirect  = redirect_q;
  assign bus.new_pc    = new_pc_q;
  assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with an expected-result queue.
//   Latency checked: outputs one edge after the request is driven.
//   Ports: drives the master side of pipeline_ctrl_if, clk and rst.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  logic clk;
  logic rst;
  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        redirect;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // Bench-side model of the stall counter.
  logic [15:0] m_cnt;
  logic        m_prev_s0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_contig(input string tag, input logic [5:0] s);
    logic [5:0] sp1;
    sp1 = s + 6'd1;
    compared++;
    assert ((sp1 & s) === 6'd0)
    else begin
      mismatched++;
      $error("FAIL %s contig: observed %b expected contiguous-from-bit0", tag, s);
    end
  endtask

  // One cycle: drive requests, queue the expected outputs, advance one
  // edge, then pop and compare.
  task automatic step(input string tag,
                      input logic id, input logic ex, input logic exc,
                      input logic eret, input logic [31:0] epc, input logic clr,
                      input logic [5:0] e_stall, input logic e_flush,
                      input logic e_redir, input logic [31:0] e_pc,
                      input logic quiet_cnt);
    exp_t e;
    exp_t got;
    bus.stallreq_id = id;
    bus.stallreq_ex = ex;
    bus.exc_req     = exc;
    bus.eret_req    = eret;
    bus.epc_i       = epc;
    bus.cnt_clr     = clr;
    e.stall = e_stall; e.flush = e_flush; e.redirect = e_redir; e.pc = e_pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (clr)                               m_cnt = 16'h0;
    else if (m_prev_s0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_prev_s0 = e_stall[0];
    got = exp_q.pop_front();
    check({tag, ".stall"},    {26'd0, bus.stall}, {26'd0, got.stall});
    check({tag, ".flush"},    {31'd0, bus.flush}, {31'd0, got.flush});
    check({tag, ".redirect"}, {31'd0, bus.redirect}, {31'd0, got.redirect});
    check({tag, ".new_pc"},   bus.new_pc, got.pc);
    check_contig(tag, bus.stall);
    if (!quiet_cnt) check({tag, ".stall_cnt"}, {16'd0, bus.stall_cnt}, {16'd0, m_cnt});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".stall"},     {26'd0, bus.stall}, 32'd0);
    check({tag, ".flush"},     {31'd0, bus.flush}, 32'd0);
    check({tag, ".redirect"},  {31'd0, bus.redirect}, 32'd0);
    check({tag, ".new_pc"},    bus.new_pc, 32'd0);
    check({tag, ".stall_cnt"}, {16'd0, bus.stall_cnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    bus.stallreq_id = 1'b0; bus.stallreq_ex = 1'b0; bus.exc_req = 1'b0;
    bus.eret_req = 1'b0; bus.epc_i = 32'h0; bus.cnt_clr = 1'b0;
    m_cnt = 16'h0; m_prev_s0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;

    // Scenario 1: decode stall for 3 cycles, counter reaches 3.
    for (int i = 0; i < 3; i++)
      step("s1_id", 1,0,0,0, 32'h0, 0, STALL_ID, 0, 0, 32'h0, 0);
    step("s1_idle", 0,0,0,0, 32'h0, 0, 6'b0, 0, 0, 32'h0, 0);
    step("s1_idle2", 0,0,0,0, 32'h0, 0, 6'b0, 0, 0, 32'h0, 0);
    check("s1_cnt_abs", {16'd0, bus.stall_cnt}, 32'd3);

    // Scenario 2: execute stall outranks decode stall.
    step("s2_ex_id", 1,1,0,0, 32'h0, 0, STALL_EX, 0, 0, 32'h0, 0);
    step("s2_ex",    0,1,0,0, 32'h0, 0, STALL_EX, 0, 0, 32'h0, 0);

    // Scenario 3: exception beats stall, then FLUSH, DRAIN; requests ignored.
    step("s3_exc",   0,1,1,0, 32'h0, 0, 6'b0, 1, 1, 32'h20, 0);
    step("s3_flush", 1,1,0,0, 32'h0, 0, 6'b0, 1, 0, 32'h20, 0);
    step("s3_drain", 1,1,1,0, 32'h0, 0, 6'b0, 0, 0, 32'h20, 0);
    step("s3_run",   1,0,0,0, 32'h0, 0, STALL_ID, 0, 0, 32'h20, 0);

    // Scenario 4: eret, with an exception arriving in FLUSH being ignored.
    step("s4_eret",  0,0,0,1, 32'h0000_1234, 0, 6'b0, 1, 1, 32'h1234, 0);
    step("s4_exc_in_flush", 0,0,1,0, 32'h0, 0, 6'b0, 1, 0, 32'h1234, 0);
    step("s4_drain", 0,0,0,0, 32'h0, 0, 6'b0, 0, 0, 32'h1234, 0);
    step("s4_run",   0,0,0,0, 32'h0, 0, 6'b0, 0, 0, 32'h1234, 0);

    // Priority: exception beats eret.
    step("prio_exc_eret", 0,0,1,1, 32'h0000_5555, 0, 6'b0, 1, 1, 32'h20, 0);
    step("prio_flush", 0,0,0,0, 32'h0, 0, 6'b0, 1, 0, 32'h20, 0);
    step("prio_drain", 0,0,0,0, 32'h0, 0, 6'b0, 0, 0, 32'h20, 0);

    // Scenario 5: long stall saturates the counter, clear wins mid-stall.
    step("s5_clr0", 0,0,0,0, 32'h0, 1, 6'b0, 0, 0, 32'h20, 0);
    for (int i = 0; i < 66000; i++)
      step("s5_hold", 1,0,0,0, 32'h0, 0, STALL_ID, 0, 0, 32'h20, (i % 4096) != 0);
    check("s5_sat", {16'd0, bus.stall_cnt}, 32'h0000_FFFF);
    step("s5_sat_hold", 1,0,0,0, 32'h0, 0, STALL_ID, 0, 0, 32'h20, 0);
    step("s5_clr",      1,0,0,0, 32'h0, 1, STALL_ID, 0, 0, 32'h20, 0);
    check("s5_clr_abs", {16'd0, bus.stall_cnt}, 32'd0);
    step("s5_after",    1,0,0,0, 32'h0, 0, STALL_ID, 0, 0, 32'h20, 0);

    // Scenario 6: asynchronous reset mid-FLUSH.
    step("s6_exc", 0,0,1,0, 32'h0, 0, 6'b0, 1, 1, 32'h20, 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("s6_async");
    @(posedge clk);
    #1;
    check_reset_state("s6_held");
    rst = 1'b1;
    m_cnt = 16'h0; m_prev_s0 = 1'b0;
    step("s6_id",   1,0,0,0, 32'h0, 0, STALL_ID, 0, 0, 32'h0, 0);
    step("s6_idle", 0,0,0,0, 32'h0, 0, 6'b0, 0, 0, 32'h0, 0);
    check("s6_cnt", {16'd0, bus.stall_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
